// File: rtl/pwm_compare.sv
// pwm_compare: compares an incoming free-running count against a duty value
// and produces a registered PWM output, a wrap pulse and a period counter.
// New duty values are accepted over a valid/ready handshake into a shadow
// register and only become active at a counter wrap, so a period is never cut
// short or stretched mid-way.
module pwm_compare #(
  parameter int W  = 8,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          res,
  input  logic [W-1:0]  cnt,
  input  logic [W-1:0]  duty_in,
  input  logic          duty_valid,
  output logic          duty_ready,
  output logic          pwm_out,
  output logic          wrap_pulse,
  output logic [PW-1:0] periods
);

  typedef enum logic {
    EMPTY  = 1'b0,
    LOADED = 1'b1
  } shadowState_t;

  shadowState_t  state_q, state_d;
  logic [W-1:0]  cnt_q;
  logic [W-1:0]  active_q, active_d;
  logic [W-1:0]  shadow_q, shadow_d;
  logic          pwm_q, pwm_d;
  logic          wrapPulse_q;
  logic [PW-1:0] periods_q, periods_d;
  logic          wrap;
  logic          transfer;
  logic [W-1:0]  dutyEff;

  // Wrap detection, handshake acceptance and next-state for the shadow FSM,
  // the active duty and the period counter. A wrap with a pending shadow value
  // swaps it in on the same cycle, so the first sample of the new period
  // already uses the new duty.
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    periods_d = periods_q;
    wrap      = (cnt < cnt_q);
    transfer  = duty_valid && (state_q == EMPTY);
    dutyEff   = (wrap && (state_q == LOADED)) ? shadow_q : active_q;
    pwm_d     = (cnt < dutyEff);
    if (wrap) begin
      periods_d = periods_q + PW'(1);
    end
    if (wrap && (state_q == LOADED)) begin
      active_d = shadow_q;
      state_d  = EMPTY;
    end else if (transfer) begin
      shadow_d = duty_in;
      state_d  = LOADED;
    end
  end

  // All state registers, with synchronous reset taking priority over every input.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= EMPTY;
      cnt_q       <= '0;
      active_q    <= '0;
      shadow_q    <= '0;
      pwm_q       <= 1'b0;
      wrapPulse_q <= 1'b0;
      periods_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt;
      active_q    <= active_d;
      shadow_q    <= shadow_d;
      pwm_q       <= pwm_d;
      wrapPulse_q <= wrap;
      periods_q   <= periods_d;
    end
  end

  assign duty_ready = (state_q == EMPTY);
  assign pwm_out    = pwm_q;
  assign wrap_pulse = wrapPulse_q;
  assign periods    = periods_q;

endmodule

// File: tb/tb_pwm_compare.sv
// tb_pwm_compare: directed and randomized stimulus for pwm_compare, checked
// every cycle against a behavioural model plus per-period high-cycle counts.
module tb_pwm_compare;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic [7:0]  cnt = '0;
  logic [7:0]  duty_in = '0;
  logic        duty_valid = 1'b0;
  logic        duty_ready;
  logic        pwm_out;
  logic        wrap_pulse;
  logic [15:0] periods;

  int checks = 0;
  int errors = 0;

  int mActive  = 0;
  int mShadow  = 0;
  bit mPending = 0;
  int mPrev    = 0;
  int mPeriods = 0;
  bit expPwm   = 0;
  bit expWrap  = 0;

  pwm_compare #(.W(8), .PW(16)) dut (
    .clk        (clk),
    .res        (res),
    .cnt        (cnt),
    .duty_in    (duty_in),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .pwm_out    (pwm_out),
    .wrap_pulse (wrap_pulse),
    .periods    (periods)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  task automatic checkOutput();
    check("pwm_out", {31'b0, pwm_out}, {31'b0, expPwm});
    check("wrap_pulse", {31'b0, wrap_pulse}, {31'b0, expWrap});
    check("periods", {16'b0, periods}, mPeriods);
    check("duty_ready", {31'b0, duty_ready}, {31'b0, !mPending});
  endtask

  // Drives one cycle of inputs, advances the model at the clock edge and
  // compares the registered outputs just after it.
  task automatic applyStimulus(input logic r, input logic [7:0] c, input logic [7:0] d, input logic v);
    bit isWrap;
    int effDuty;
    res        = r;
    cnt        = c;
    duty_in    = d;
    duty_valid = v;
    @(posedge clk);
    if (r) begin
      mActive  = 0;
      mShadow  = 0;
      mPending = 0;
      mPrev    = 0;
      mPeriods = 0;
      expPwm   = 0;
      expWrap  = 0;
    end else begin
      isWrap  = (int'(c) < mPrev);
      effDuty = (isWrap && mPending) ? mShadow : mActive;
      expPwm  = (int'(c) < effDuty);
      expWrap = isWrap;
      if (isWrap) mPeriods = (mPeriods + 1) % 65536;
      if (isWrap && mPending) begin
        mActive  = mShadow;
        mPending = 0;
      end else if (v && !mPending) begin
        mShadow  = int'(d);
        mPending = 1;
      end
      mPrev = int'(c);
    end
    #1;
    checkOutput();
  endtask

  // Runs one full counter period 0..255, optionally offering a duty value at
  // one count, and returns the number of high pwm samples seen.
  task automatic runPeriod(input bit doLoad, input int loadAt, input logic [7:0] loadVal, output int highs);
    highs = 0;
    for (int k = 0; k < 256; k++) begin
      applyStimulus(1'b0, 8'(k), loadVal, doLoad && (k == loadAt));
      if (pwm_out === 1'b1) highs++;
    end
  endtask

  initial begin
    int highs;
    int guard;

    $display("[TB] reset");
    applyStimulus(1'b1, 8'd0, 8'd0, 1'b0);
    applyStimulus(1'b1, 8'd33, 8'd99, 1'b1);
    check("reset pwm_out", {31'b0, pwm_out}, 32'd0);
    check("reset duty_ready", {31'b0, duty_ready}, 32'd1);
    check("reset periods", {16'b0, periods}, 32'd0);

    $display("[TB] free run, no duty");
    runPeriod(1'b0, 0, 8'd0, highs);
    check("period0 highs", highs, 0);
    check("no wrap before first wrap", {16'b0, periods}, 32'd0);
    runPeriod(1'b0, 0, 8'd0, highs);
    check("idle highs", highs, 0);
    check("periods after first wrap", {16'b0, periods}, 32'd1);

    $display("[TB] load 64");
    runPeriod(1'b1, 10, 8'd64, highs);
    check("pre-wrap highs (duty 0)", highs, 0);
    runPeriod(1'b0, 0, 8'd0, highs);
    check("duty 64 highs", highs, 64);

    $display("[TB] load 200 mid-period");
    runPeriod(1'b1, 100, 8'd200, highs);
    check("still 64 after mid load", highs, 64);
    runPeriod(1'b0, 0, 8'd0, highs);
    check("duty 200 highs", highs, 200);

    $display("[TB] load 128 on the wrap cycle");
    runPeriod(1'b1, 0, 8'd128, highs);
    check("wrap-cycle load deferred", highs, 200);
    runPeriod(1'b0, 0, 8'd0, highs);
    check("duty 128 highs", highs, 128);

    $display("[TB] boundary duties");
    runPeriod(1'b1, 5, 8'd0, highs);
    check("before duty 0", highs, 128);
    runPeriod(1'b1, 5, 8'd255, highs);
    check("duty 0 highs", highs, 0);
    runPeriod(1'b0, 0, 8'd0, highs);
    check("duty 255 highs", highs, 255);

    $display("[TB] randomized counts and handshakes");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] reset mid-period with pending shadow");
    runPeriod(1'b1, 0, 8'd40, highs);
    for (int k = 0; k < 60; k++) begin
      applyStimulus(1'b0, 8'(k), 8'd77, k == 10);
    end
    check("pending before reset", {31'b0, duty_ready}, 32'd0);
    applyStimulus(1'b1, 8'd60, 8'd0, 1'b0);
    check("after reset pwm_out", {31'b0, pwm_out}, 32'd0);
    check("after reset periods", {16'b0, periods}, 32'd0);
    check("after reset duty_ready", {31'b0, duty_ready}, 32'd1);
    for (int k = 61; k < 256; k++) begin
      applyStimulus(1'b0, 8'(k), 8'd0, 1'b0);
    end
    runPeriod(1'b0, 0, 8'd0, highs);
    check("discarded shadow never applied", highs, 0);

    $display("[TB] period counter rollover");
    guard = 0;
    while (mPeriods != 65535 && guard < 70000) begin
      applyStimulus(1'b0, 8'(255 - (guard % 256)), 8'd0, 1'b0);
      guard++;
    end
    check("rollover reached max in budget", {31'b0, guard < 70000}, 32'd1);
    check("periods at max", {16'b0, periods}, 32'd65535);
    while (mPeriods != 0 && guard < 70600) begin
      applyStimulus(1'b0, 8'(255 - (guard % 256)), 8'd0, 1'b0);
      guard++;
    end
    check("rollover wrapped in budget", {31'b0, guard < 70600}, 32'd1);
    check("periods rolled to 0", {16'b0, periods}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_compare.md
Name: pwm_compare

Overview:
- Downstream consumer of the 8-bit free-running counter value.
- Compares the incoming count against a duty register and produces a registered PWM output, a one-cycle wrap pulse, and a count of completed periods.
- New duty values arrive over a valid/ready handshake. They are held in a shadow register and take effect only at a counter wrap, so the output never glitches mid-period.

Parameters:
- W, 8, width of count and duty values.
- PW, 16, width of the completed-period counter.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- res  input  1  reset.
- cnt  input  W  current counter value from the upstream counter, same clock domain.
- duty_in  input  W  requested duty (number of high cycles per 2^W-cycle period).
- duty_valid  input  1  duty_in is valid this cycle.
- duty_ready  output  1  block can accept a duty value this cycle.
- pwm_out  output  1  PWM waveform, registered.
- wrap_pulse  output  1  one-cycle pulse, registered, on the cycle after a wrap is detected.
- periods  output  PW  number of wraps seen since reset, modulo 2^PW.

Interface rule (already decided): one clock, clk. Reset res is synchronous and active-high: sampled only on the rising clk edge, and asserted when res=1.

Behaviour:
- Reset (res=1 at a clk edge) clears all state, overriding every other input on that edge:
  - pwm_out=0, wrap_pulse=0, periods=0, duty_ready=1;
  - active duty=0, shadow pending=0, shadow value=0, previous-count register cnt_q=0.
- State: a two-state shadow FSM.
  - EMPTY: pending=0, duty_ready=1.
  - LOADED: pending=1, duty_ready=0.
  - duty_ready is a direct decode of state (no combinational path from duty_valid).
- Handshake: a transfer occurs when duty_valid=1 and duty_ready=1 at a clk edge. duty_in is captured into the shadow register and the state goes EMPTY->LOADED. duty_valid while in LOADED is ignored (upstream holds the value).
- Wrap detect:
  - Combinational wrap = (cnt < cnt_q), with cnt_q <= cnt every cycle.
  - Counter held at 0 (upstream in reset) gives no wrap.
  - The first cycle after reset never wraps, because cnt_q=0.
- On a wrap cycle:
  - if LOADED: active duty <= shadow value, state -> EMPTY (duty_ready=1 from the next cycle);
  - wrap_pulse <= 1, otherwise wrap_pulse <= 0;
  - periods <= periods+1, wrapping from 2^PW-1 to 0.
- Handshake arriving on a wrap cycle while EMPTY: the value is captured into the shadow and applied at the NEXT wrap, not the current one.
- Duty in effect: duty_eff = shadow value if (wrap and LOADED), else active duty.
- PWM: pwm_out <= (cnt < duty_eff), unsigned W-bit compare. Latency is 1 cycle from cnt to pwm_out.
- Boundaries:
  - duty=0: pwm_out constantly 0.
  - duty=2^W-1: pwm_out low only for the sample at cnt=2^W-1.
  - A 100% duty cycle is not representable; this is accepted.
- Non-monotonic input (cnt jumps backwards, not via a wrap) is treated as a wrap; no error flag.
- Reset mid-period: pwm_out drops to 0 on the reset edge, and any pending shadow value is discarded.

Test Plan:
1. Reset, then drive cnt 0,1,2,...,255,0,... one step per clk with no duty loaded -> pwm_out=0 throughout; wrap_pulse high exactly 1 cycle after cnt 255->0; periods=1 after the first wrap.
2. Load duty_in=64 at cnt=10 -> duty_ready falls the next cycle; pwm_out stays 0 until the wrap; then 64 high cycles and 192 low cycles per period; duty_ready=1 after the wrap.
3. With duty=64 active, load duty_in=200 at cnt=100 -> the current period keeps 64 high cycles; the change takes effect at the next wrap; no glitch at cnt=100.
4. Assert duty_valid with duty_in=128 on the exact wrap cycle while EMPTY -> the following period still uses the old duty; duty=128 applies one wrap later.
5. Boundary duties: duty_in=0 -> pwm_out never high; duty_in=255 -> pwm_out low only for 1 cycle per 256.
6. Assert res for 1 cycle mid-period with a pending shadow value -> next cycle: pwm_out=0, periods=0, duty_ready=1; the pending value is never applied. Run 65536 wraps (forced cnt sequence) -> periods rolls over from 65535 to 0.
